regfile_wb_arbiter: RTL and testbench

Writeback arbiter driving the single write port of the core register file from two result producers (ALU and load/memory unit). Each producer hands results over a valid/ready handshake into a private 2-entry FIFO. A fixed-priority arbiter with anti-starvation pops one result per cycle into a registered write stage that drives `wr_en`/`wr_idx`/`wr_data`. The block also exports a pending-write mask for hazard tracking and, optionally, bypass data for the two register-file read ports.

---
 rtl/regfile_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two 2-entry result FIFOs (ALU, MEM) feeding a registered register-file
// write stage. Define REGFILE_WB_BYPASS_EN to enable the read-port bypass outputs.
module regfile_wb_arbiter #(
    parameter int N_BITS      = 32,
    parameter int N_REGS      = 32,
    parameter int STARVE_MAX  = 3,
    localparam int N_IDX      = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [N_IDX-1:0]  alu_idx,
    input  logic [N_BITS-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [N_IDX-1:0]  mem_idx,
    input  logic [N_BITS-1:0] mem_data,
    output logic              wr_en,
    output logic [N_IDX-1:0]  wr_idx,
    output logic [N_BITS-1:0] wr_data,
    output logic [N_REGS-1:0] pend_mask,
    input  logic [N_IDX-1:0]  rd0_idx,
    input  logic [N_IDX-1:0]  rd1_idx,
    output logic              byp0_hit,
    output logic              byp1_hit,
    output logic [N_BITS-1:0] byp0_data,
    output logic [N_BITS-1:0] byp1_data
);
    localparam int S_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [S_W-1:0] STARVE_LIM = S_W'(STARVE_MAX);

    // Source 0 is the ALU, source 1 is the memory unit.
    logic              in_valid [2];
    logic [N_IDX-1:0]  in_idx   [2];
    logic [N_BITS-1:0] in_data  [2];
    logic              ready    [2];
    logic              head_v   [2];
    logic              push     [2];
    logic              grant    [2];

    logic [1:0]        cnt_q   [2];
    logic [1:0]        cnt_d   [2];
    logic [N_IDX-1:0]  fidx_q  [2][2];
    logic [N_IDX-1:0]  fidx_d  [2][2];
    logic [N_BITS-1:0] fdata_q [2][2];
    logic [N_BITS-1:0] fdata_d [2][2];
    logic [S_W-1:0]    starve_q, starve_d;
    logic              wr_en_q, wr_en_d;
    logic [N_IDX-1:0]  wr_idx_q, wr_idx_d;
    logic [N_BITS-1:0] wr_data_q, wr_data_d;

    assign in_valid[0] = alu_valid;
    assign in_idx[0]   = alu_idx;
    assign in_data[0]  = alu_data;
    assign in_valid[1] = mem_valid;
    assign in_idx[1]   = mem_idx;
    assign in_data[1]  = mem_data;

    for (genvar s = 0; s < 2; s++) begin : g_src
        assign ready[s]  = (cnt_q[s] != 2'd2);
        assign head_v[s] = (cnt_q[s] != 2'd0);
        // Register 0 results complete the handshake but are dropped here.
        assign push[s]   = in_valid[s] & ready[s] & (in_idx[s] != '0);
    end

    assign grant[1] = head_v[1] & (~head_v[0] | (starve_q != STARVE_LIM));
    assign grant[0] = head_v[0] & ~grant[1];

    assign alu_ready = ready[0];
    assign mem_ready = ready[1];

    always_comb begin
        cnt_d   = cnt_q;
        fidx_d  = fidx_q;
        fdata_d = fdata_q;
        for (int unsigned s = 0; s < 2; s++) begin
            if (grant[s] && push[s]) begin
                // Pop with push only happens at count 1, so the new entry becomes the head.
                fidx_d[s][0]  = in_idx[s];
                fdata_d[s][0] = in_data[s];
            end else if (grant[s]) begin
                fidx_d[s][0]  = fidx_q[s][1];
                fdata_d[s][0] = fdata_q[s][1];
                cnt_d[s]      = cnt_q[s] - 2'd1;
            end else if (push[s]) begin
                fidx_d[s][cnt_q[s][0]]  = in_idx[s];
                fdata_d[s][cnt_q[s][0]] = in_data[s];
                cnt_d[s]                = cnt_q[s] + 2'd1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!head_v[0] || grant[0]) begin
            starve_d = '0;
        end else if (grant[1] && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + S_W'(1);
        end
    end

    always_comb begin
        wr_en_d   = grant[0] | grant[1];
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (grant[1]) begin
            wr_idx_d  = fidx_q[1][0];
            wr_data_d = fdata_q[1][0];
        end else if (grant[0]) begin
            wr_idx_d  = fidx_q[0][0];
            wr_data_d = fdata_q[0][0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < 2; s++) begin
                cnt_q[s] <= '0;
                for (int unsigned k = 0; k < 2; k++) begin
                    fidx_q[s][k]  <= '0;
                    fdata_q[s][k] <= '0;
                end
            end
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            fidx_q    <= fidx_d;
            fdata_q   <= fdata_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_idx  = wr_idx_q;
    assign wr_data = wr_data_q;

    always_comb begin
        pend_mask = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            if (head_v[s])          pend_mask[fidx_q[s][0]] = 1'b1;
            if (cnt_q[s] == 2'd2)   pend_mask[fidx_q[s][1]] = 1'b1;
        end
        if (wr_en_q) pend_mask[wr_idx_q] = 1'b1;
        pend_mask[0] = 1'b0;
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign byp0_hit  = wr_en_q & (wr_idx_q == rd0_idx) & (rd0_idx != '0);
    assign byp1_hit  = wr_en_q & (wr_idx_q == rd1_idx) & (rd1_idx != '0);
    assign byp0_data = byp0_hit ? wr_data_q : '0;
    assign byp1_data = byp1_hit ? wr_data_q : '0;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^{rd0_idx, rd1_idx};
    assign byp0_hit  = 1'b0;
    assign byp1_hit  = 1'b0;
    assign byp0_data = '0;
    assign byp1_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wb_arbiter;
    localparam int NB   = 32;
    localparam int NR   = 32;
    localparam int NI   = 5;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic          alu_ready, mem_ready;
    logic [NI-1:0] alu_idx = '0, mem_idx = '0, rd0_idx = '0, rd1_idx = '0;
    logic [NB-1:0] alu_data = '0, mem_data = '0;
    logic          wr_en, byp0_hit, byp1_hit;
    logic [NI-1:0] wr_idx;
    logic [NB-1:0] wr_data, byp0_data, byp1_data;
    logic [NR-1:0] pend_mask;

    regfile_wb_arbiter #(.N_BITS(NB), .N_REGS(NR), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_idx(alu_idx), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_idx(mem_idx), .mem_data(mem_data),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .pend_mask(pend_mask),
        .rd0_idx(rd0_idx), .rd1_idx(rd1_idx),
        .byp0_hit(byp0_hit), .byp1_hit(byp1_hit), .byp0_data(byp0_data), .byp1_data(byp1_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NI-1:0] idx;
        logic [NB-1:0] data;
    } ent_t;

    ent_t          aq[$];
    ent_t          mq[$];
    int            starve;
    bit            m_wr_en;
    logic [NI-1:0] m_wr_idx;
    logic [NB-1:0] m_wr_data;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        mq.delete();
        starve    = 0;
        m_wr_en   = 1'b0;
        m_wr_idx  = '0;
        m_wr_data = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit   a_fire, m_fire;
        int   win;
        ent_t e;
        a_fire = alu_valid && (aq.size() < 2);
        m_fire = mem_valid && (mq.size() < 2);
        if (mq.size() != 0 && (aq.size() == 0 || starve != SMAX)) win = 2;
        else if (aq.size() != 0) win = 1;
        else win = 0;
        if (aq.size() == 0 || win == 1) starve = 0;
        else if (win == 2 && starve < SMAX) starve++;
        m_wr_en = (win != 0);
        if (win == 1) begin
            e = aq.pop_front();
            m_wr_idx = e.idx; m_wr_data = e.data;
        end else if (win == 2) begin
            e = mq.pop_front();
            m_wr_idx = e.idx; m_wr_data = e.data;
        end
        if (a_fire && alu_idx != 0) begin
            e.idx = alu_idx; e.data = alu_data; aq.push_back(e);
        end
        if (m_fire && mem_idx != 0) begin
            e.idx = mem_idx; e.data = mem_data; mq.push_back(e);
        end
    endtask

    task automatic compare_all();
        logic [NR-1:0] ep;
        bit            h0, h1;
        ep = '0;
        foreach (aq[i]) ep[aq[i].idx] = 1'b1;
        foreach (mq[i]) ep[mq[i].idx] = 1'b1;
        if (m_wr_en) ep[m_wr_idx] = 1'b1;
        ep[0] = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        h0 = m_wr_en && (m_wr_idx == rd0_idx) && (rd0_idx != 0);
        h1 = m_wr_en && (m_wr_idx == rd1_idx) && (rd1_idx != 0);
`else
        h0 = 1'b0;
        h1 = 1'b0;
`endif
        chk("alu_ready", 64'(alu_ready), 64'(aq.size() < 2));
        chk("mem_ready", 64'(mem_ready), 64'(mq.size() < 2));
        chk("wr_en", 64'(wr_en), 64'(m_wr_en));
        chk("wr_idx", 64'(wr_idx), 64'(m_wr_idx));
        chk("wr_data", 64'(wr_data), 64'(m_wr_data));
        chk("pend_mask", 64'(pend_mask), 64'(ep));
        chk("byp0_hit", 64'(byp0_hit), 64'(h0));
        chk("byp1_hit", 64'(byp1_hit), 64'(h1));
        chk("byp0_data", 64'(byp0_data), h0 ? 64'(m_wr_data) : 64'(0));
        chk("byp1_data", 64'(byp1_data), h1 ? 64'(m_wr_data) : 64'(0));
    endtask

    // Entered and left at a falling edge; inputs for this cycle are already driven.
    task automatic tick();
        #1;
        compare_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string seq;
        int    ka, km;
        bit    saw_a0, saw_m0;

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_pend", 64'(pend_mask), 64'(0));
        chk("rst_alu_ready", 64'(alu_ready), 64'(1));
        chk("rst_mem_ready", 64'(mem_ready), 64'(1));
        rst_n = 1'b1;
        idle(2);

        // Single ALU write to r5.
        alu_valid = 1'b1; alu_idx = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        chk("t1_c2_wr_en", 64'(wr_en), 64'(0));
        chk("t1_c2_pend", 64'(pend_mask), 64'h20);
        tick();
        chk("t1_c3_wr_en", 64'(wr_en), 64'(1));
        chk("t1_c3_wr_idx", 64'(wr_idx), 64'(5));
        chk("t1_c3_wr_data", 64'(wr_data), 64'hDEADBEEF);
        chk("t1_c3_pend", 64'(pend_mask), 64'h20);
        tick();
        chk("t1_c4_wr_en", 64'(wr_en), 64'(0));
        chk("t1_c4_pend", 64'(pend_mask), 64'(0));
        idle(2);

        // Register 0 from MEM is accepted and dropped.
        mem_valid = 1'b1; mem_idx = 5'd0; mem_data = 32'h1234;
        chk("t3_mem_ready", 64'(mem_ready), 64'(1));
        tick();
        mem_valid = 1'b0;
        repeat (3) begin
            chk("t3_wr_en", 64'(wr_en), 64'(0));
            chk("t3_pend", 64'(pend_mask), 64'(0));
            tick();
        end

        // Back-to-back ALU writes to r3 keep order with no bubble.
        alu_valid = 1'b1; alu_idx = 5'd3; alu_data = 32'd1;
        tick();
        chk("t7_pend", 64'(pend_mask), 64'h8);
        alu_data = 32'd2;
        tick();
        alu_valid = 1'b0;
        chk("t7_w1_en", 64'(wr_en), 64'(1));
        chk("t7_w1_data", 64'(wr_data), 64'(1));
        tick();
        chk("t7_w2_en", 64'(wr_en), 64'(1));
        chk("t7_w2_idx", 64'(wr_idx), 64'(3));
        chk("t7_w2_data", 64'(wr_data), 64'(2));
        tick();
        chk("t7_done", 64'(wr_en), 64'(0));
        idle(2);

        // Bypass on r7 while it sits in the write stage.
        alu_valid = 1'b1; alu_idx = 5'd7; alu_data = 32'hA5A5A5A5;
        tick();
        alu_valid = 1'b0;
        tick();
        rd0_idx = 5'd7; rd1_idx = 5'd8;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        chk("t5_byp0_hit", 64'(byp0_hit), 64'(1));
        chk("t5_byp0_data", 64'(byp0_data), 64'hA5A5A5A5);
`else
        chk("t5_byp0_hit", 64'(byp0_hit), 64'(0));
        chk("t5_byp0_data", 64'(byp0_data), 64'(0));
`endif
        chk("t5_byp1_hit", 64'(byp1_hit), 64'(0));
        tick();
        rd0_idx = '0; rd1_idx = '0;
        idle(3);

        // Both sources saturated: ALU (r1..r15) vs MEM (r16..r31) ordering.
        seq = ""; ka = 0; km = 0; saw_a0 = 0; saw_m0 = 0;
        for (int c = 0; c < 14; c++) begin
            alu_valid = 1'b1; alu_idx = 5'(1 + ka % 15); alu_data = 32'(ka);
            mem_valid = 1'b1; mem_idx = 5'(16 + km % 16); mem_data = 32'(km + 256);
            if (!alu_ready) saw_a0 = 1'b1;
            if (!mem_ready) saw_m0 = 1'b1;
            if (alu_ready) ka++;
            if (mem_ready) km++;
            tick();
            if (wr_en && seq.len() < 8) seq = {seq, (wr_idx >= 5'd16) ? "M" : "A"};
        end
        n_cmp++;
        if (seq != "MMMAMMMA") begin
            n_bad++;
            $display("FAIL t4_order: got %s expected MMMAMMMA", seq);
        end
        chk("t4_alu_ready_dropped", 64'(saw_a0), 64'(1));
        chk("t4_mem_ready_dropped", 64'(saw_m0), 64'(1));

        // Reset with both FIFOs loaded discards everything.
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_wr_en", 64'(wr_en), 64'(0));
        chk("t6_wr_idx", 64'(wr_idx), 64'(0));
        chk("t6_wr_data", 64'(wr_data), 64'(0));
        chk("t6_pend", 64'(pend_mask), 64'(0));
        chk("t6_alu_ready", 64'(alu_ready), 64'(1));
        chk("t6_mem_ready", 64'(mem_ready), 64'(1));
        chk("t6_byp0_hit", 64'(byp0_hit), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            chk("t6_no_write", 64'(wr_en), 64'(0));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_idx   = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 99) < 60);
            mem_idx   = 5'($urandom_range(0, 31));
            mem_data  = $urandom;
            rd0_idx   = ($urandom_range(0, 1) != 0) ? m_wr_idx : 5'($urandom_range(0, 31));
            rd1_idx   = 5'($urandom_range(0, 31));
            tick();
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
